// File: rtl/flight_loop_sequencer.sv
// One control-loop iteration per IMU sample: angle controller, body-frame controller, mixer update.
// Optional loop-time statistics output enabled by defining FLIGHT_LOOP_STATS_EN.
module flight_loop_sequencer #(
  parameter int TIMEOUT_US      = 2000,
  parameter int TIMEOUT_WIDTH   = 12,
  parameter int RECOVER_LOOPS   = 4,
  parameter int FAULT_CNT_WIDTH = 8
) (
  input  logic                       us_clk,
  input  logic                       reset,
  input  logic                       imu_good,
  input  logic                       imu_valid_strobe,
  input  logic                       ac_complete,
  input  logic                       bf_complete,
  output logic                       ac_start,
  output logic                       bf_start,
  output logic                       mixer_update,
  output logic                       failsafe,
  output logic                       busy,
  output logic                       overrun,
  output logic [2:0]                 state,
  output logic [FAULT_CNT_WIDTH-1:0] fault_count,
`ifdef FLIGHT_LOOP_STATS_EN
  output logic [15:0]                loop_time_max,
`endif
  output logic [FAULT_CNT_WIDTH-1:0] overrun_count
);

  localparam int GOOD_W = $clog2(RECOVER_LOOPS + 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_US - 1);
  localparam logic [GOOD_W-1:0]        GOOD_MAX = GOOD_W'(RECOVER_LOOPS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START_AC = 3'd1,
    S_WAIT_AC  = 3'd2,
    S_START_BF = 3'd3,
    S_WAIT_BF  = 3'd4,
    S_UPDATE   = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  state_t                     state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0]   tmo_q, tmo_d;
  logic [GOOD_W-1:0]          good_q, good_d;
  logic                       failsafe_q, failsafe_d;
  logic                       overrun_q, overrun_d;
  logic [FAULT_CNT_WIDTH-1:0] fault_cnt_q, fault_cnt_d;
  logic [FAULT_CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;
`ifdef FLIGHT_LOOP_STATS_EN
  logic [15:0]                lt_q, lt_d;
  logic [15:0]                lt_max_q, lt_max_d;
`endif

  // State register and bookkeeping flops
  always_ff @(posedge us_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      good_q      <= '0;
      failsafe_q  <= 1'b1;
      overrun_q   <= 1'b0;
      fault_cnt_q <= '0;
      ovr_cnt_q   <= '0;
`ifdef FLIGHT_LOOP_STATS_EN
      lt_q        <= '0;
      lt_max_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      good_q      <= good_d;
      failsafe_q  <= failsafe_d;
      overrun_q   <= overrun_d;
      fault_cnt_q <= fault_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
`ifdef FLIGHT_LOOP_STATS_EN
      lt_q        <= lt_d;
      lt_max_q    <= lt_max_d;
`endif
    end
  end

  // Next-state logic; losing imu_good anywhere in flight aborts to FAULT
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (imu_valid_strobe && imu_good) state_d = S_START_AC;
      end
      S_START_AC: begin
        tmo_d   = '0;
        state_d = imu_good ? S_WAIT_AC : S_FAULT;
      end
      S_WAIT_AC: begin
        if (!imu_good)             state_d = S_FAULT;
        else if (ac_complete)      state_d = S_START_BF;
        else if (tmo_q == TMO_LAST) state_d = S_FAULT;
        else                       tmo_d   = tmo_q + TIMEOUT_WIDTH'(1);
      end
      S_START_BF: begin
        tmo_d   = '0;
        state_d = imu_good ? S_WAIT_BF : S_FAULT;
      end
      S_WAIT_BF: begin
        if (!imu_good)             state_d = S_FAULT;
        else if (bf_complete)      state_d = S_UPDATE;
        else if (tmo_q == TMO_LAST) state_d = S_FAULT;
        else                       tmo_d   = tmo_q + TIMEOUT_WIDTH'(1);
      end
      S_UPDATE: state_d = imu_good ? S_IDLE : S_FAULT;
      S_FAULT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Failsafe recovery, fault and overrun accounting
  always_comb begin
    good_d      = good_q;
    failsafe_d  = failsafe_q;
    fault_cnt_d = fault_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    overrun_d   = 1'b0;
    if (state_q == S_UPDATE && imu_good) begin
      if (good_q < GOOD_MAX) good_d = good_q + GOOD_W'(1);
      if (good_d == GOOD_MAX) failsafe_d = 1'b0;
    end
    if (state_q == S_FAULT) begin
      failsafe_d = 1'b1;
      good_d     = '0;
      if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + FAULT_CNT_WIDTH'(1);
    end
    if (state_q == S_IDLE && !imu_good) begin
      failsafe_d = 1'b1;
      good_d     = '0;
    end
    if (state_q != S_IDLE && imu_valid_strobe && imu_good) begin
      overrun_d = 1'b1;
      if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + FAULT_CNT_WIDTH'(1);
    end
  end

`ifdef FLIGHT_LOOP_STATS_EN
  // Loop time reads START_AC-to-UPDATE distance while in the UPDATE state
  always_comb begin
    lt_d     = lt_q;
    lt_max_d = lt_max_q;
    if (state_q == S_START_AC)                 lt_d = 16'd1;
    else if (state_q != S_IDLE && lt_q != '1)  lt_d = lt_q + 16'd1;
    if (state_q == S_UPDATE && imu_good && lt_q > lt_max_q) lt_max_d = lt_q;
  end

  assign loop_time_max = lt_max_q;
`endif

  // Output decode
  always_comb begin
    ac_start      = (state_q == S_START_AC);
    bf_start      = (state_q == S_START_BF);
    mixer_update  = (state_q == S_UPDATE);
    busy          = (state_q != S_IDLE);
    state         = state_q;
    failsafe      = failsafe_q;
    overrun       = overrun_q;
    fault_count   = fault_cnt_q;
    overrun_count = ovr_cnt_q;
  end

endmodule

// File: tb/tb_flight_loop_sequencer.sv
// Bench for flight_loop_sequencer: table of loop scenarios plus hand sequences, pulse scoreboard.
// Define FLIGHT_LOOP_STATS_EN to also exercise loop_time_max.
module tb_flight_loop_sequencer;
  localparam int FCW = 8;
  localparam int TMO = 2000;

  logic us_clk = 1'b0;
  logic reset = 1'b1;
  logic imu_good = 1'b1;
  logic imu_valid_strobe = 1'b0;
  logic ac_complete = 1'b0;
  logic bf_complete = 1'b0;
  logic ac_start, bf_start, mixer_update, failsafe, busy, overrun;
  logic [2:0] state;
  logic [FCW-1:0] fault_count, overrun_count;
`ifdef FLIGHT_LOOP_STATS_EN
  logic [15:0] loop_time_max;
`endif

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_ac[$];
  int exp_bf[$];
  int exp_up[$];
  int exp_fault[$];
  int exp_ovr[$];
  bit exp_upfs[$];

  typedef struct {
    int a;       // ac_complete offset from strobe, -1 = withheld
    int b;       // bf_complete offset from strobe, -1 = withheld
    int ovr;     // second strobe offset, 0 = none
    int drop;    // imu_good drop offset, 0 = none
    bit fs_up;   // failsafe seen during UPDATE
    bit exp_fs;  // failsafe after loop
    int exp_flt;
    int exp_ovr;
  } vec_t;

  flight_loop_sequencer #(
    .TIMEOUT_US(TMO), .TIMEOUT_WIDTH(12), .RECOVER_LOOPS(4), .FAULT_CNT_WIDTH(FCW)
  ) dut (
    .us_clk(us_clk), .reset(reset), .imu_good(imu_good),
    .imu_valid_strobe(imu_valid_strobe), .ac_complete(ac_complete), .bf_complete(bf_complete),
    .ac_start(ac_start), .bf_start(bf_start), .mixer_update(mixer_update),
    .failsafe(failsafe), .busy(busy), .overrun(overrun), .state(state),
    .fault_count(fault_count),
`ifdef FLIGHT_LOOP_STATS_EN
    .loop_time_max(loop_time_max),
`endif
    .overrun_count(overrun_count)
  );

  always #5 us_clk = ~us_clk;
  always @(posedge us_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge us_clk);
    #1;
  endtask

  // Scoreboard: each observed pulse must match the next expected cycle
  always @(negedge us_clk) begin
    if (ac_start | bf_start | mixer_update)
      chk("pulse_onehot", int'(ac_start) + int'(bf_start) + int'(mixer_update), 1);
    if (ac_start) begin
      if (exp_ac.size() == 0) chk("ac_start_unexpected", cyc, -1);
      else chk("ac_start_cycle", cyc, exp_ac.pop_front());
    end
    if (bf_start) begin
      if (exp_bf.size() == 0) chk("bf_start_unexpected", cyc, -1);
      else chk("bf_start_cycle", cyc, exp_bf.pop_front());
    end
    if (mixer_update) begin
      if (exp_up.size() == 0) chk("mixer_update_unexpected", cyc, -1);
      else begin
        chk("mixer_update_cycle", cyc, exp_up.pop_front());
        chk("failsafe_at_update", int'(failsafe), int'(exp_upfs.pop_front()));
      end
    end
    if (state == 3'd6) begin
      if (exp_fault.size() == 0) chk("fault_unexpected", cyc, -1);
      else chk("fault_cycle", cyc, exp_fault.pop_front());
    end
    if (overrun) begin
      if (exp_ovr.size() == 0) chk("overrun_unexpected", cyc, -1);
      else chk("overrun_cycle", cyc, exp_ovr.pop_front());
    end
  end

  task automatic run_loop(input int a, input int b, input int ovr, input int drop,
                          input bit fs_up, input bit chk_end);
    int s;
    bit done;
    done = 1'b0;
    s = cyc;
    exp_ac.push_back(s + 1);
    if (a >= 0) exp_bf.push_back(s + a + 1);
    if (b >= 0) begin
      exp_up.push_back(s + b + 1);
      exp_upfs.push_back(fs_up);
    end
    if (drop > 0)   exp_fault.push_back(s + drop + 1);
    else if (a < 0) exp_fault.push_back(s + 2 + TMO);
    else if (b < 0) exp_fault.push_back(s + a + 2 + TMO);
    if (ovr > 0) exp_ovr.push_back(s + ovr + 1);
    for (int t = 0; t < 2100 && !done; t++) begin
      imu_valid_strobe = (t == 0) || (ovr > 0 && t == ovr);
      ac_complete      = (t == a);
      bf_complete      = (t == b);
      imu_good         = !(drop > 0 && t >= drop);
      tick();
      if (!busy) done = 1'b1;
    end
    imu_valid_strobe = 1'b0;
    ac_complete      = 1'b0;
    bf_complete      = 1'b0;
    imu_good         = 1'b1;
    if (!done) chk("loop_never_idle", 0, 1);
    if (chk_end && b >= 0) chk("loop_end_cycle", cyc - s, b + 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[13];
    int s;
    tbl[0]  = '{5, 10, 0, 0, 1'b1, 1'b1, 0, 0};
    tbl[1]  = '{2, 4, 0, 0, 1'b1, 1'b1, 0, 0};
    tbl[2]  = '{3, 6, 3, 0, 1'b1, 1'b1, 0, 1};
    tbl[3]  = '{4, 9, 0, 0, 1'b1, 1'b0, 0, 1};
    tbl[4]  = '{2, 5, 0, 0, 1'b0, 1'b0, 0, 1};
    tbl[5]  = '{-1, -1, 0, 0, 1'b1, 1'b1, 1, 1};
    tbl[6]  = '{3, 7, 0, 0, 1'b1, 1'b1, 1, 1};
    tbl[7]  = '{3, 7, 0, 0, 1'b1, 1'b1, 1, 1};
    tbl[8]  = '{3, 7, 0, 0, 1'b1, 1'b1, 1, 1};
    tbl[9]  = '{3, 7, 0, 0, 1'b1, 1'b0, 1, 1};
    tbl[10] = '{3, -1, 0, 6, 1'b1, 1'b1, 2, 1};
    tbl[11] = '{-1, -1, 0, 1, 1'b1, 1'b1, 3, 1};
    tbl[12] = '{2, -1, 0, 0, 1'b1, 1'b1, 4, 1};

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_failsafe", int'(failsafe), 1);
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({ac_start, bf_start, mixer_update, overrun}), 0);
    chk("rst_fault_count", int'(fault_count), 0);
    chk("rst_overrun_count", int'(overrun_count), 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (i == 5) begin
        // Strobe with imu_good low in IDLE is ignored and forces failsafe
        imu_good = 1'b0;
        imu_valid_strobe = 1'b1;
        tick();
        imu_valid_strobe = 1'b0;
        chk("good_low_state", int'(state), 0);
        chk("good_low_failsafe", int'(failsafe), 1);
        chk("good_low_fault_count", int'(fault_count), 0);
        chk("good_low_overrun_count", int'(overrun_count), 1);
        imu_good = 1'b1;
        tick();
      end
      run_loop(tbl[i].a, tbl[i].b, tbl[i].ovr, tbl[i].drop, tbl[i].fs_up, 1'b1);
      chk($sformatf("row%0d_failsafe", i), int'(failsafe), int'(tbl[i].exp_fs));
      chk($sformatf("row%0d_fault_count", i), int'(fault_count), tbl[i].exp_flt);
      chk($sformatf("row%0d_overrun_count", i), int'(overrun_count), tbl[i].exp_ovr);
      chk($sformatf("row%0d_state", i), int'(state), 0);
    end

    for (int i = 0; i < 300; i++) run_loop(-1, -1, 0, 2, 1'b1, 1'b0);
    chk("fault_count_saturated", int'(fault_count), 255);
    chk("sat_failsafe", int'(failsafe), 1);

    // Reset in the middle of WAIT_AC
    s = cyc;
    exp_ac.push_back(s + 1);
    imu_valid_strobe = 1'b1;
    tick();
    imu_valid_strobe = 1'b0;
    tick();
    chk("midrst_pre_state", int'(state), 2);
    reset = 1'b1;
    tick();
    chk("midrst_state", int'(state), 0);
    chk("midrst_fault_count", int'(fault_count), 0);
    chk("midrst_overrun_count", int'(overrun_count), 0);
    chk("midrst_failsafe", int'(failsafe), 1);
    reset = 1'b0;
    repeat (4) tick();
    chk("midrst_idle", int'(busy), 0);

`ifdef FLIGHT_LOOP_STATS_EN
    chk("stats_reset", int'(loop_time_max), 0);
    run_loop(5, 12, 0, 0, 1'b1, 1'b1);
    chk("stats_after_12", int'(loop_time_max), 12);
    run_loop(10, 40, 0, 0, 1'b1, 1'b1);
    chk("stats_after_40", int'(loop_time_max), 40);
    run_loop(5, 20, 0, 0, 1'b1, 1'b1);
    chk("stats_after_20", int'(loop_time_max), 40);
`endif

    tick();
    chk("pending_ac", exp_ac.size(), 0);
    chk("pending_bf", exp_bf.size(), 0);
    chk("pending_update", exp_up.size(), 0);
    chk("pending_fault", exp_fault.size(), 0);
    chk("pending_overrun", exp_ovr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
